led_seq_pwm: RTL and testbench
==============================

Name: led_seq_pwm

Overview:
Multi-channel LED sequencer with a programmable number of colour slots. Each slot has its own duration in ticks, and each channel has a global PWM dimmer. It supports loop and one-shot modes and skips zero-duration slots. It drives the board LED / GPIO outputs directly from the FPGA fabric and replaces the fixed 3-colour, 4-slot controller.

Parameters:
NUM_CH, 3, number of output channels (R,G,B,...)
NUM_SLOTS, 4, number of sequencer slots (>=1)
DUR_W, 12, slot duration width in ticks
PWM_W, 8, PWM duty width per channel (>=2)
TICK_DIV, 12000, clk cycles per tick (1 ms at 12 MHz; >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
run  in  1  level; 1 = sequencer enabled
oneshot  in  1  1 = stop after last non-zero slot; 0 = loop
slot_dur  in  NUM_SLOTS*DUR_W  duration of slot k at [k*DUR_W +: DUR_W], in ticks; 0 = skip slot
slot_color  in  NUM_SLOTS*NUM_CH  on/off mask of slot k at [k*NUM_CH +: NUM_CH]
ch_duty  in  NUM_CH*PWM_W  duty of channel c at [c*PWM_W +: PWM_W]
led_out  out  NUM_CH  registered channel drive, active-high
slot_idx  out  clog2(NUM_SLOTS) (min 1)  currently active slot
busy  out  1  1 while in RUN
done  out  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset (rst_n=0, async): state=IDLE, prescaler=0, tick counter=0, pwm_cnt=0. Outputs led_out=0, slot_idx=0, busy=0, done=0.
- Prescaler:
  - Held at 0 outside RUN.
  - In RUN it counts 0..TICK_DIV-1 and wraps.
  - tick = (prescaler==TICK_DIV-1).
- States:
  - IDLE: leave when run=1 and any slot_dur!=0. Load slot_idx with the lowest k having dur!=0 and cnt=slot_dur[k]. Go to RUN next clock.
  - RUN:
    - On tick with cnt>1: cnt decrements.
    - On tick with cnt==1: search indices slot_idx+1..NUM_SLOTS-1 for the next non-zero slot.
    - If one is found, load it and stay in RUN.
    - If none is found (wrap), oneshot=0: search from 0 upward. A single non-zero slot reloads itself. If no non-zero slot remains, go to IDLE.
    - If none is found (wrap), oneshot=1: go to DONE, with done=1 for exactly that cycle.
  - DONE: led_out=0. Stay until run=0, then go to IDLE.
  - run=0 in any state: go to IDLE next clock, prescaler=0, busy=0. run=0 has priority over a same-cycle tick.
- Slot timing: a slot with duration d occupies exactly d*TICK_DIV clocks. Durations are sampled only at slot load; changes mid-slot take effect at the next load.
- Zero-duration slots are never entered. slot_dur changes are seen at the next search.
- PWM:
  - pwm_cnt free-runs 0..2^PWM_W-2 and wraps, so the period is 2^PWM_W-1 clocks. It runs in all states except reset.
  - pwm_on[c] = (pwm_cnt < ch_duty[c]). Duty 0 = always off; duty 2^PWM_W-1 = always on.
- Output: led_out[c] <= busy_state && slot_color[slot_idx][c] && pwm_on[c]. This is registered, so there is 1 clock latency from state/pwm_cnt. slot_color is sampled live, not latched.
- busy = (state==RUN), registered with state.
- Reset mid-operation: all state and outputs clear immediately. The sequence restarts from the lowest non-zero slot after rst_n deasserts and run=1.
- A slot index beyond the valid range or an illegal state encoding recovers to IDLE.

Test Plan:
Params for all scenarios: NUM_CH=3, NUM_SLOTS=4, DUR_W=4, PWM_W=3 (period 7), TICK_DIV=4, all duty=7.
1. Loop: dur={2,1,3,1}, colors {100,010,001,111}, oneshot=0, run=1 -> slot_idx holds 8,4,12,4 clocks per slot and repeats. led_out follows the colour one clock later.
2. Skip: dur={0,2,0,1} -> slot sequence 1,3,1,3..., slot 0 and slot 2 are never seen. All dur=0 -> stays IDLE, busy=0, led_out=0.
3. One-shot: oneshot=1, dur={1,1,0,0} -> 8 clocks of RUN, then done pulses for exactly 1 cycle and led_out=0. Stays in DONE until run=0, then restarts on run=1.
4. PWM: slot colour 111, duty={0,3,7} -> over 7 clocks ch0 high 0, ch1 high 3, ch2 high 7. Duty change applies within one PWM period.
5. Abort/reset: run drops mid-slot on a tick cycle -> IDLE next clock, no advance, led_out=0. rst_n pulsed low asynchronously between clocks -> outputs 0 immediately, restart from lowest non-zero slot.
6. Mid-slot duration write: change slot_dur[0] 2->5 during slot 0 -> current slot still lasts 8 clocks, next visit lasts 20 clocks.

Source files
------------

// File: rtl/led_seq_pwm.sv
// Multi-channel LED sequencer: steps through colour slots of programmable tick
// length (zero-length slots skipped) and dims each channel with a shared-period PWM.
//
//   state  | meaning
//   S_IDLE | sequencer stopped, prescaler held at 0, outputs dark
//   S_RUN  | a slot is active, counting ticks down to the next slot load
//   S_DONE | one-shot sequence finished, outputs dark until run drops
module led_seq_pwm #(
  parameter  int NUM_CH    = 3,
  parameter  int NUM_SLOTS = 4,
  parameter  int DUR_W     = 12,
  parameter  int PWM_W     = 8,
  parameter  int TICK_DIV  = 12000,
  localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic                          oneshot,
  input  logic [NUM_SLOTS*DUR_W-1:0]    slot_dur,
  input  logic [NUM_SLOTS*NUM_CH-1:0]   slot_color,
  input  logic [NUM_CH*PWM_W-1:0]       ch_duty,
  output logic [NUM_CH-1:0]             led_out,
  output logic [IDX_W-1:0]              slot_idx,
  output logic                          busy,
  output logic                          done
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [PWM_W-1:0] PWM_LAST = PWM_W'((2 ** PWM_W) - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PS_W-1:0]     presc_q, presc_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    slot_idx_q, slot_idx_d;
  logic [PWM_W-1:0]    pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0]   led_q, led_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                any_nz, next_found, idx_valid, tick;
  logic [IDX_W-1:0]    first_idx, next_idx;
  logic [DUR_W-1:0]    first_dur, next_dur;
  logic [NUM_CH-1:0]   cur_color;

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    any_nz     = 1'b0;
    next_found = 1'b0;
    first_idx  = '0;
    next_idx   = '0;
    first_dur  = '0;
    next_dur   = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (slot_dur[k*DUR_W +: DUR_W] != '0) begin
        any_nz    = 1'b1;
        first_idx = IDX_W'(k);
        first_dur = slot_dur[k*DUR_W +: DUR_W];
        if (k > int'(slot_idx_q)) begin
          next_found = 1'b1;
          next_idx   = IDX_W'(k);
          next_dur   = slot_dur[k*DUR_W +: DUR_W];
        end
      end
    end
  end

  always_comb begin
    idx_valid = 1'b0;
    cur_color = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (int'(slot_idx_q) == k) begin
        idx_valid = 1'b1;
        cur_color = slot_color[k*NUM_CH +: NUM_CH];
      end
    end
  end

  assign tick = (state_q == S_RUN) && (presc_q == PS_LAST);

  always_comb begin
    state_d    = state_q;
    presc_d    = '0;
    cnt_d      = cnt_q;
    slot_idx_d = slot_idx_q;
    done_d     = 1'b0;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_nz) begin
            state_d    = S_RUN;
            slot_idx_d = first_idx;
            cnt_d      = first_dur;
          end
        end
        S_RUN: begin
          if (!idx_valid) begin
            state_d = S_IDLE;
          end else if (!tick) begin
            presc_d = presc_q + 1'b1;
          end else if (cnt_q > DUR_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else if (next_found) begin
            slot_idx_d = next_idx;
            cnt_d      = next_dur;
          end else if (oneshot) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (any_nz) begin
            slot_idx_d = first_idx;
            cnt_d      = first_dur;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 1'b1;
    busy_d    = (state_d == S_RUN);
    for (int c = 0; c < NUM_CH; c++) begin
      led_d[c] = (state_q == S_RUN) && cur_color[c] &&
                 (pwm_cnt_q < ch_duty[c*PWM_W +: PWM_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      cnt_q      <= '0;
      slot_idx_q <= '0;
      pwm_cnt_q  <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      slot_idx_q <= slot_idx_d;
      pwm_cnt_q  <= pwm_cnt_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign led_out  = led_q;
  assign slot_idx = slot_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_led_seq_pwm.sv
// Directed bench for led_seq_pwm with small parameters (4-clock tick, 7-clock PWM).
module tb_led_seq_pwm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        oneshot;
  logic [15:0] slot_dur;
  logic [11:0] slot_color;
  logic [8:0]  ch_duty;
  logic [2:0]  led_out;
  logic [1:0]  slot_idx;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;
  int h0, h1, h2;

  led_seq_pwm #(
    .NUM_CH(3), .NUM_SLOTS(4), .DUR_W(4), .PWM_W(3), .TICK_DIV(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .oneshot(oneshot),
    .slot_dur(slot_dur), .slot_color(slot_color), .ch_duty(ch_duty),
    .led_out(led_out), .slot_idx(slot_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge of the first RUN cycle (cycle 1).
  task automatic restart();
    run = 1'b0;
    step();
    run = 1'b1;
    step();
  endtask

  // Loop pattern {2,1,3,1} ticks -> 8,4,12,4 clocks, period 28.
  function automatic logic [1:0] exp_idx_s1(input int i);
    int p;
    p = (i - 1) % 28;
    if (p < 8)       return 2'd0;
    else if (p < 12) return 2'd1;
    else if (p < 24) return 2'd2;
    else             return 2'd3;
  endfunction

  function automatic logic [2:0] col_s1(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  // Skip pattern {0,2,0,1}: slot 1 for 8 clocks, slot 3 for 4, period 12.
  function automatic logic [1:0] exp_idx_s2(input int i);
    return (((i - 1) % 12) < 8) ? 2'd1 : 2'd3;
  endfunction

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    oneshot    = 1'b0;
    slot_dur   = {4'd1, 4'd3, 4'd1, 4'd2};
    slot_color = {3'b111, 3'b001, 3'b010, 3'b100};
    ch_duty    = {3'd7, 3'd7, 3'd7};
    #1;
    check_eq("rst_led", led_out, 0);
    check_eq("rst_idx", slot_idx, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("idle_busy", busy, 0);

    // 1. loop mode
    restart();
    for (int i = 1; i <= 56; i++) begin
      check_eq($sformatf("s1_idx_c%0d", i), slot_idx, exp_idx_s1(i));
      check_eq($sformatf("s1_led_c%0d", i), led_out, (i == 1) ? 3'b000 : col_s1(exp_idx_s1(i - 1)));
      check_eq($sformatf("s1_busy_c%0d", i), busy, 1);
      step();
    end

    // 2. zero-duration skip, then all zero
    run      = 1'b0;
    slot_dur = {4'd1, 4'd0, 4'd2, 4'd0};
    restart();
    for (int i = 1; i <= 24; i++) begin
      check_eq($sformatf("s2_idx_c%0d", i), slot_idx, exp_idx_s2(i));
      if (i > 1)
        check_eq($sformatf("s2_led_c%0d", i), led_out, (exp_idx_s2(i - 1) == 2'd1) ? 3'b010 : 3'b111);
      step();
    end
    run      = 1'b0;
    step();
    slot_dur = '0;
    run      = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_eq("s2_zero_busy", busy, 0);
    check_eq("s2_zero_led", led_out, 0);

    // 3. one-shot
    run      = 1'b0;
    slot_dur = {4'd0, 4'd0, 4'd1, 4'd1};
    oneshot  = 1'b1;
    restart();
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("s3_busy_c%0d", i), busy, 1);
      check_eq($sformatf("s3_done_c%0d", i), done, 0);
      step();
    end
    check_eq("s3_done_pulse", done, 1);
    check_eq("s3_busy_done", busy, 0);
    step();
    check_eq("s3_done_low", done, 0);
    check_eq("s3_led_dark", led_out, 0);
    for (int i = 0; i < 5; i++) step();
    check_eq("s3_hold_busy", busy, 0);
    check_eq("s3_hold_done", done, 0);
    check_eq("s3_hold_led", led_out, 0);
    restart();
    check_eq("s3_restart_busy", busy, 1);
    check_eq("s3_restart_idx", slot_idx, 0);
    oneshot = 1'b0;

    // 4. PWM duty
    run        = 1'b0;
    slot_dur   = {4'd0, 4'd0, 4'd0, 4'd15};
    slot_color = {3'b000, 3'b000, 3'b000, 3'b111};
    ch_duty    = {3'd7, 3'd3, 3'd0};
    restart();
    step();
    step();
    h0 = 0; h1 = 0; h2 = 0;
    for (int i = 0; i < 7; i++) begin
      h0 += int'(led_out[0]); h1 += int'(led_out[1]); h2 += int'(led_out[2]);
      step();
    end
    check_eq("s4_ch0_duty0", h0, 0);
    check_eq("s4_ch1_duty3", h1, 3);
    check_eq("s4_ch2_duty7", h2, 7);
    ch_duty = {3'd7, 3'd5, 3'd0};
    for (int i = 0; i < 7; i++) step();
    h1 = 0;
    for (int i = 0; i < 7; i++) begin
      h1 += int'(led_out[1]);
      step();
    end
    check_eq("s4_ch1_duty5", h1, 5);
    ch_duty = {3'd7, 3'd7, 3'd7};

    // 5. run drop on the last tick of slot 0, then async reset
    run        = 1'b0;
    slot_dur   = {4'd1, 4'd3, 4'd1, 4'd2};
    slot_color = {3'b111, 3'b001, 3'b010, 3'b100};
    restart();
    for (int i = 1; i < 8; i++) step();
    run = 1'b0;
    step();
    check_eq("s5_abort_busy", busy, 0);
    check_eq("s5_abort_idx", slot_idx, 0);
    step();
    check_eq("s5_abort_led", led_out, 0);
    run = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_eq("s5_pre_rst_idx", slot_idx, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("s5_rst_led", led_out, 0);
    check_eq("s5_rst_idx", slot_idx, 0);
    check_eq("s5_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("s5_rerun_busy", busy, 1);
    check_eq("s5_rerun_idx", slot_idx, 0);
    for (int i = 1; i < 8; i++) step();
    check_eq("s5_rerun_c8", slot_idx, 0);
    step();
    check_eq("s5_rerun_c9", slot_idx, 1);

    // 6. duration change while slot 0 is active
    restart();
    for (int i = 1; i <= 49; i++) begin
      if (i == 3) slot_dur[3:0] = 4'd5;
      case (i)
        8:  check_eq("s6_c8", slot_idx, 0);
        9:  check_eq("s6_c9", slot_idx, 1);
        28: check_eq("s6_c28", slot_idx, 3);
        29: check_eq("s6_c29", slot_idx, 0);
        48: check_eq("s6_c48", slot_idx, 0);
        49: check_eq("s6_c49", slot_idx, 1);
        default: ;
      endcase
      if (i < 49) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
